// File: rtl/belt_multi_if.sv
// belt_multi_if: drop, read and status signals of the belt operand store.
// The master side (core pipeline) drives drops and read positions.
// The slave side (belt_multi) returns registered read data, validity,
// occupancy and the illegal-drop error pulse.
interface belt_multi_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
);
  localparam int PW = $clog2(DEPTH);

  logic [1:0]       drop_cnt;
  logic [WIDTH-1:0] wdata0;
  logic [WIDTH-1:0] wdata1;
  logic             clear;
  logic [PW-1:0]    r1;
  logic [PW-1:0]    r2;
  logic [WIDTH-1:0] rdata1;
  logic [WIDTH-1:0] rdata2;
  logic             rvalid1;
  logic             rvalid2;
  logic [PW:0]      count;
  logic             err;

  modport master (
    output drop_cnt, wdata0, wdata1, clear, r1, r2,
    input  rdata1, rdata2, rvalid1, rvalid2, count, err
  );

  modport slave (
    input  drop_cnt, wdata0, wdata1, clear, r1, r2,
    output rdata1, rdata2, rvalid1, rvalid2, count, err
  );
endinterface

// File: rtl/belt_multi.sv
// belt_multi: circular belt operand store, WIDTH bits by DEPTH slots.
// Takes up to two drops per cycle, serves two relative-position reads with
// one cycle of registered latency, tracks occupancy and supports a clear.
// Optional macro BELT_FWD_EN: reads see the post-drop, post-clear belt in
// the same cycle (incoming values are bypassed to the read ports).
module belt_multi #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int PW = $clog2(DEPTH)
) (
  input logic       clk,
  input logic       rst,
  belt_multi_if.slave bus
);

  // Slot storage is never reset; only pointers and outputs are.
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0]    idx_q, idx_d;
  logic [PW:0]      count_q, count_d;
  logic [PW+1:0]    count_sum;
  logic [1:0]       drop_n;
  logic             we0, we1;
  logic [PW-1:0]    waddr0, waddr1;

  logic [WIDTH-1:0] rdata1_q, rdata1_d;
  logic [WIDTH-1:0] rdata2_q, rdata2_d;
  logic             rvalid1_q, rvalid1_d;
  logic             rvalid2_q, rvalid2_d;
  logic             err_q, err_d;
  logic [PW-1:0]    slot1, slot2;

  // Decode the drop request, next write pointer and saturating occupancy.
  always_comb begin
    drop_n    = (bus.drop_cnt == 2'd3) ? 2'd0 : bus.drop_cnt;
    we0       = (drop_n != 2'd0);
    we1       = (drop_n == 2'd2);
    waddr0    = idx_q;
    waddr1    = idx_q + PW'(1);
    idx_d     = idx_q + PW'(drop_n);
    count_sum = (bus.clear ? '0 : {1'b0, count_q}) + (PW+2)'(drop_n);
    if (count_sum > (PW+2)'(DEPTH)) begin
      count_d = (PW+1)'(DEPTH);
    end else begin
      count_d = count_sum[PW:0];
    end
    err_d     = (bus.drop_cnt == 2'd3);
  end

  // Map read positions to slots and choose read data and validity.
`ifdef BELT_FWD_EN
  always_comb begin
    slot1     = idx_d - PW'(1) - bus.r1;
    slot2     = idx_d - PW'(1) - bus.r2;
    rdata1_d  = mem_q[slot1];
    rdata2_d  = mem_q[slot2];
    if (bus.r1 < PW'(drop_n)) begin
      rdata1_d = (bus.r1 == '0 && drop_n == 2'd2) ? bus.wdata1 : bus.wdata0;
    end
    if (bus.r2 < PW'(drop_n)) begin
      rdata2_d = (bus.r2 == '0 && drop_n == 2'd2) ? bus.wdata1 : bus.wdata0;
    end
    rvalid1_d = ({1'b0, bus.r1} < count_d);
    rvalid2_d = ({1'b0, bus.r2} < count_d);
  end
`else
  always_comb begin
    slot1     = idx_q - PW'(1) - bus.r1;
    slot2     = idx_q - PW'(1) - bus.r2;
    rdata1_d  = mem_q[slot1];
    rdata2_d  = mem_q[slot2];
    rvalid1_d = ({1'b0, bus.r1} < count_q);
    rvalid2_d = ({1'b0, bus.r2} < count_q);
  end
`endif

  // Write dropped values into the array; reset blocks writes in its cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (we0) mem_q[waddr0] <= bus.wdata0;
      if (we1) mem_q[waddr1] <= bus.wdata1;
    end
  end

  // Register pointers, occupancy, read results and the error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q     <= '0;
      count_q   <= '0;
      rdata1_q  <= '0;
      rdata2_q  <= '0;
      rvalid1_q <= 1'b0;
      rvalid2_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      count_q   <= count_d;
      rdata1_q  <= rdata1_d;
      rdata2_q  <= rdata2_d;
      rvalid1_q <= rvalid1_d;
      rvalid2_q <= rvalid2_d;
      err_q     <= err_d;
    end
  end

  assign bus.rdata1  = rdata1_q;
  assign bus.rdata2  = rdata2_q;
  assign bus.rvalid1 = rvalid1_q;
  assign bus.rvalid2 = rvalid2_q;
  assign bus.count   = count_q;
  assign bus.err     = err_q;

endmodule
